// File: rtl/johnson_pkg.sv
// Shared types and pure helpers for the Johnson step sequencer.
// The helpers work on a JW_MAX-bit container, so any register width up to JW_MAX can use them.
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;
  localparam int   JW_MAX  = 32;

  // Bits of code at position w and above must be zero; the result keeps them zero.
  function automatic logic [JW_MAX-1:0] johnson_next(input logic [JW_MAX-1:0] code,
                                                     input int w,
                                                     input logic dir);
    logic [JW_MAX-1:0] mask;
    logic [JW_MAX-1:0] top;
    logic [JW_MAX-1:0] res;
    mask = ~({JW_MAX{1'b1}} << w);
    top  = code >> (w - 1);
    if (dir == DIR_FWD)
      res = (code >> 1) | ({{(JW_MAX-1){1'b0}}, ~code[0]} << (w - 1));
    else
      res = (code << 1) | {{(JW_MAX-1){1'b0}}, ~top[0]};
    return res & mask;
  endfunction

  function automatic logic johnson_valid(input logic [JW_MAX-1:0] code, input int w);
    logic [JW_MAX-1:0] edges;
    edges = (code ^ (code >> 1)) & ~({JW_MAX{1'b1}} << (w - 1));
    return ($countones(edges) <= 1);
  endfunction

endpackage

// File: rtl/johnson_step_core.sv
// Phase register of the Johnson generator: advances one code per step_en in the given direction.
// With JOHNSON_SELF_CORRECT_EN defined, an illegal code is forced back to zero and err pulses.
module johnson_step_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             dir,
  output logic [WIDTH-1:0] phase,
  output logic             err
);

  logic [WIDTH-1:0] phase_q;
  logic [WIDTH-1:0] next_code;

  always_comb begin
    next_code = WIDTH'(johnson_next(JW_MAX'(phase_q), WIDTH, dir));
  end

`ifdef JOHNSON_SELF_CORRECT_EN
  logic err_q;

  // Recovery beats a pending step; the step still counts upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      err_q   <= 1'b0;
    end else if (!johnson_valid(JW_MAX'(phase_q), WIDTH)) begin
      phase_q <= '0;
      err_q   <= 1'b1;
    end else begin
      err_q <= 1'b0;
      if (step_en)
        phase_q <= next_code;
    end
  end

  assign err = err_q;
`else
  always_ff @(posedge clk) begin
    if (reset)
      phase_q <= '0;
    else if (step_en)
      phase_q <= next_code;
  end

  assign err = 1'b0;
`endif

  assign phase = phase_q;

endmodule

// File: rtl/johnson_step_sequencer.sv
// Command-driven sequencer: issues a counted, rate-divided run of Johnson phase steps per command.
// Optional illegal-code recovery in the phase core is enabled by JOHNSON_SELF_CORRECT_EN.
module johnson_step_sequencer
  import johnson_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_div,
  input  logic              abort,
  output logic [WIDTH-1:0]  phase,
  output logic              step_pulse,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  state_t            state, state_nx;
  logic              dir_q;
  logic [STEP_W-1:0] remaining;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  divider;
  logic              accept;
  logic              tick;
  logic              step_pulse_q;
  logic              aborted_q;

  assign accept = (state == IDLE) && cmd_valid;
  // Abort suppresses a coinciding step; the run ends one cycle after its last step.
  assign tick   = (state == RUN) && !abort && (remaining != '0) && (divider == '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = (cmd_steps == '0) ? DONE : RUN;
      RUN:     if (abort || (remaining == '0)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dir_q        <= DIR_FWD;
      remaining    <= '0;
      div_q        <= '0;
      divider      <= '0;
      step_pulse_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state        <= state_nx;
      step_pulse_q <= tick;
      aborted_q    <= (state == RUN) && abort;
      if (accept) begin
        dir_q     <= cmd_dir;
        div_q     <= cmd_div;
        divider   <= cmd_div;
        remaining <= cmd_steps;
      end else if (tick) begin
        remaining <= remaining - STEP_W'(1);
        divider   <= div_q;
      end else if ((state == RUN) && (divider != '0)) begin
        divider <= divider - DIV_W'(1);
      end
    end
  end

  johnson_step_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .step_en (tick),
    .dir     (dir_q),
    .phase   (phase),
    .err     (err)
  );

  assign cmd_ready  = (state == IDLE) && !reset;
  assign busy       = (state == RUN) && !reset;
  assign done       = (state == DONE) && !reset;
  assign aborted    = aborted_q && !reset;
  assign step_pulse = step_pulse_q;

endmodule
